// File: rtl/mux4_pkg.sv
// Shared constants and helpers for the 4-to-1 round-robin streaming mux.
package mux4_pkg;
   localparam int NCH   = 4;
   localparam int SEL_W = 2;

   // NCH is a power of two, so the SEL_W-bit add wraps 3 -> 0 by itself.
   function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] idx);
      return SEL_W'(idx + 1'b1);
   endfunction
endpackage

// File: rtl/rr_arbiter4.sv
// Rotating-priority arbiter: scans req starting at ptr and grants the first
// requester. The pointer moves past the winner only on an actual transfer.
module rr_arbiter4
   import mux4_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NCH-1:0]   req,
   input  logic             advance,
   input  logic [SEL_W-1:0] advance_idx,
   output logic             grant_valid,
   output logic [SEL_W-1:0] grant_idx
);

   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] idx;

   assign ptr_d = advance ? rr_next(advance_idx) : ptr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

   // Walk from the farthest offset back to ptr so the nearest requester wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = ptr_q;
      idx         = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         idx = SEL_W'(ptr_q + SEL_W'(i));
         if (req[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = idx;
         end
      end
   end

endmodule

// File: rtl/mux4_rr.sv
// 4-to-1 valid/ready stream merger with round-robin arbitration and a
// registered output carrying the source channel index.
module mux4_rr
   import mux4_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SEL_W-1:0]     out_sel,
   output logic                 out_valid,
   input  logic                 out_ready
);

   logic             load_en;
   logic             xfer;
   logic             grant_valid;
   logic [SEL_W-1:0] grant_idx;

   logic [WIDTH-1:0] data_q, data_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             valid_q, valid_d;

   rr_arbiter4 u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (in_valid),
      .advance     (xfer),
      .advance_idx (grant_idx),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // Output slot is free when empty or being drained this cycle.
   assign load_en = ~valid_q | out_ready;
   assign xfer    = load_en & grant_valid & rst_n;

   always_comb begin
      in_ready = '0;
      if (xfer) in_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      data_d  = data_q;
      sel_d   = sel_q;
      valid_d = valid_q;
      if (xfer) begin
         data_d  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
         sel_d   = grant_idx;
         valid_d = 1'b1;
      end else if (load_en) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         sel_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
      end
   end

   assign out_data  = data_q;
   assign out_sel   = sel_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_mux4_rr.sv
// Bench for mux4_rr: directed scenarios plus random traffic, checked against a
// cycle-level behavioural model and a per-channel demux-side scoreboard.
module tb_mux4_rr;

   logic        clk;
   logic        rst_n;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_sel;
   logic        out_valid;
   logic        out_ready;

   int vectors;
   int miscompares;

   // Behavioural model state
   int         m_ptr;
   bit         m_valid;
   logic [7:0] m_data;
   int         m_sel;
   logic [7:0] sb [4][$];

   mux4_rr #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr   = 0;
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_sel   = 0;
      for (int k = 0; k < 4; k++) sb[k].delete();
   endtask

   // One clock: drive at negedge, check ready before the edge, update model
   // at the edge, check registered outputs just after it.
   task automatic cycle(input logic [3:0] v, input logic [31:0] d, input logic r);
      int         g;
      bit         le;
      logic [3:0] er;
      logic [7:0] want;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      #1;
      le = !m_valid || r;
      g  = -1;
      for (int i = 0; i < 4; i++)
         if (g < 0 && v[(m_ptr + i) % 4]) g = (m_ptr + i) % 4;
      er = (le && g >= 0) ? 4'(1 << g) : 4'b0000;
      chk("in_ready", {28'b0, in_ready}, {28'b0, er});
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         chk("sb_word_pending", {31'b0, sb[out_sel].size() > 0}, 32'd1);
         if (sb[out_sel].size() > 0) begin
            want = sb[out_sel].pop_front();
            chk("sb_data", {24'b0, out_data}, {24'b0, want});
         end
      end
      @(posedge clk);
      if (le && g >= 0) begin
         m_data  = d[g*8 +: 8];
         m_sel   = g;
         m_valid = 1'b1;
         m_ptr   = (g + 1) % 4;
         sb[g].push_back(m_data);
      end else if (le) begin
         m_valid = 1'b0;
      end
      #1;
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      chk("out_data", {24'b0, out_data}, {24'b0, m_data});
      chk("out_sel", {30'b0, out_sel}, 32'(m_sel));
      @(negedge clk);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      model_reset();

      // Reset state with all channels requesting
      rst_n     = 1'b0;
      in_valid  = 4'b1111;
      in_data   = $urandom;
      out_ready = 1'b1;
      #1;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_data", {24'b0, out_data}, 32'd0);
      chk("rst_out_sel", {30'b0, out_sel}, 32'd0);
      chk("rst_in_ready", {28'b0, in_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Round-robin sweep, first grant after reset is channel 0
      for (int i = 0; i < 8; i++) begin
         cycle(4'b1111, 32'h33221100, 1'b1);
         chk("sweep_sel", {30'b0, out_sel}, 32'(i % 4));
         chk("sweep_data", {24'b0, out_data}, 32'(8'h11 * (i % 4)));
         chk("sweep_valid", {31'b0, out_valid}, 32'd1);
      end

      // Sparse requests: 1,3 then channel 3 drops -> 1,1
      begin
         int exp_sparse [4] = '{1, 3, 1, 1};
         for (int i = 0; i < 4; i++) begin
            cycle((i < 2) ? 4'b1010 : 4'b0010, $urandom, 1'b1);
            chk("sparse_sel", {30'b0, out_sel}, 32'(exp_sparse[i]));
         end
      end

      // Backpressure: hold A5 from channel 2 for five stalled cycles
      cycle(4'b0100, 32'h00A50000, 1'b1);
      chk("bp_load_sel", {30'b0, out_sel}, 32'd2);
      for (int i = 0; i < 5; i++) begin
         cycle(4'b1111, $urandom, 1'b0);
         chk("bp_hold_data", {24'b0, out_data}, 32'h000000A5);
         chk("bp_hold_sel", {30'b0, out_sel}, 32'd2);
         chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      end
      cycle(4'b1111, $urandom, 1'b1);
      chk("bp_release_sel", {30'b0, out_sel}, 32'd3);

      // Idle drain keeps data/sel and pointer
      cycle(4'b0000, $urandom, 1'b1);
      chk("idle_valid", {31'b0, out_valid}, 32'd0);
      chk("idle_sel", {30'b0, out_sel}, 32'd3);
      cycle(4'b1111, $urandom, 1'b1);
      chk("idle_next_sel", {30'b0, out_sel}, 32'd0);

      // Random traffic and backpressure
      for (int i = 0; i < 400; i++)
         cycle(4'($urandom), $urandom, 1'(($urandom % 4) != 0));

      // Reset pulse while stalled with a word held
      cycle(4'b1111, $urandom, 1'b1);
      cycle(4'b1111, $urandom, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("midrst_in_ready", {28'b0, in_ready}, 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(4'b1111, $urandom, 1'b1);
      chk("midrst_next_sel", {30'b0, out_sel}, 32'd0);
      for (int i = 0; i < 50; i++)
         cycle(4'($urandom), $urandom, 1'(($urandom % 3) != 0));

      // Drain and confirm every accepted word came out exactly once
      cycle(4'b0000, $urandom, 1'b1);
      cycle(4'b0000, $urandom, 1'b1);
      for (int k = 0; k < 4; k++)
         chk("sb_leftover", 32'(sb[k].size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
